// File: rtl/game_input_pkg.sv
// Shared constants, payload type and helpers for the button-to-move path.
package game_input_pkg;

    localparam int unsigned NUM_BTNS          = 4;
    localparam int unsigned DIR_W             = 2;
    localparam int unsigned DEBOUNCE_BITS_DEF = 18;

    localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd1;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd2;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd3;

    // One-entry move slot.
    typedef struct packed {
        logic             valid;
        logic [DIR_W-1:0] dir;
    } move_slot_t;

    // Highest-priority press: up > down > left > right.
    function automatic logic [DIR_W-1:0] pick_dir(input logic [NUM_BTNS-1:0] press);
        logic [DIR_W-1:0] dir;
        dir = DIR_RIGHT;
        if (press[2]) dir = DIR_LEFT;
        if (press[1]) dir = DIR_DOWN;
        if (press[0]) dir = DIR_UP;
        return dir;
    endfunction

    // {right,left,down,up} one-hot of a direction code.
    function automatic logic [NUM_BTNS-1:0] dir_onehot(input logic [DIR_W-1:0] dir);
        return NUM_BTNS'(4'b0001 << dir);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: two-flop synchronizer followed by a persistence-count debouncer.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_BITS = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o
);

    logic                     sync1_q;
    logic                     sync2_q;
    logic                     stable_q;
    logic                     stable_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q;
    logic [DEBOUNCE_BITS-1:0] cnt_d;

    // Synchronizer chain for the asynchronous pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // A level change must persist until the counter saturates before it is accepted.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == '1) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + DEBOUNCE_BITS'(1);
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/move_input_conditioner.sv
// Debounces the four game buttons and queues one move per clean press
// in a single-entry slot consumed on the frame tick.
module move_input_conditioner
    import game_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_BITS = DEBOUNCE_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_raw,
    input  logic                frame_tick,
    input  logic                enable,
    output logic                move_valid,
    output logic [DIR_W-1:0]    move_dir,
    output logic [NUM_BTNS-1:0] move_onehot,
    output logic                any_pressed
);

    logic [NUM_BTNS-1:0] stable;
    logic [NUM_BTNS-1:0] stable_dly_q;
    logic [NUM_BTNS-1:0] press;
    move_slot_t          slot_q;
    move_slot_t          slot_d;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_BITS (DEBOUNCE_BITS)
        ) u_deb (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (btn_raw[i]),
            .stable_o (stable[i])
        );
    end

    // Delayed debounced levels for rising-edge (press) detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_dly_q <= '0;
        end else begin
            stable_dly_q <= stable;
        end
    end

    // Press events only; releases are ignored.
    always_comb begin
        press = stable & ~stable_dly_q;
    end

    // Slot update: disable flushes, consume frees, a free slot takes the top press.
    always_comb begin
        slot_d = slot_q;
        if (!enable) begin
            slot_d.valid = 1'b0;
        end else begin
            if (slot_q.valid && frame_tick) begin
                slot_d.valid = 1'b0;
            end
            if (!slot_d.valid && (press != '0)) begin
                slot_d.valid = 1'b1;
                slot_d.dir   = pick_dir(press);
            end
        end
    end

    // Slot register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign move_valid  = slot_q.valid;
    assign move_dir    = slot_q.dir;
    assign move_onehot = slot_q.valid ? dir_onehot(slot_q.dir) : '0;
    assign any_pressed = |stable;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed bench for move_input_conditioner with a short debounce window.
module tb_move_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic       frame_tick;
    logic       enable;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [3:0] move_onehot;
    logic       any_pressed;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [3:0] btn;
        logic       en;
        logic       tk;
        logic       ev;
        logic [1:0] ed;
        logic [3:0] eo;
        logic       ea;
    } vec_t;

    vec_t tbl [23];

    move_input_conditioner #(
        .DEBOUNCE_BITS (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .frame_tick  (frame_tick),
        .enable      (enable),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .move_onehot (move_onehot),
        .any_pressed (any_pressed)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] b, input logic en, input logic tk,
                                input logic ev, input logic [1:0] ed,
                                input logic [3:0] eo, input logic ea);
        vec_t v;
        v.btn = b; v.en = en; v.tk = tk;
        v.ev = ev; v.ed = ed; v.eo = eo; v.ea = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic ev, input logic [1:0] ed,
                       input logic [3:0] eo, input logic ea);
        n_vec++;
        if (move_valid !== ev || move_dir !== ed || move_onehot !== eo || any_pressed !== ea) begin
            n_miss++;
            $display("FAIL %s: valid/dir/onehot/any got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                     name, move_valid, move_dir, move_onehot, any_pressed, ev, ed, eo, ea);
        end
    endtask

    // Apply inputs for n clock edges; ends just after the last edge.
    task automatic run(input logic [3:0] b, input logic en, input logic tk, input int n);
        btn_raw    = b;
        enable     = en;
        frame_tick = tk;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset      = 1'b0;
        btn_raw    = 4'b0000;
        frame_tick = 1'b0;
        enable     = 1'b1;
        #1 reset = 1'b1;
        #1 chk("reset_state", 1'b0, 2'd0, 4'b0000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Clean press of up, consume, release, then a 3-cycle glitch on left.
        for (int i = 0; i < 5; i++)   tbl[i] = mk(4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        tbl[5] = mk(4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
        tbl[6] = mk(4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1);
        tbl[7] = mk(4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1);
        tbl[8] = mk(4'b0001, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1);
        tbl[9] = mk(4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
        for (int i = 10; i < 15; i++) tbl[i] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
        tbl[15] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        for (int i = 16; i < 19; i++) tbl[i] = mk(4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        for (int i = 19; i < 23; i++) tbl[i] = mk(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);

        for (int i = 0; i < 23; i++) begin
            run(tbl[i].btn, tbl[i].en, tbl[i].tk, 1);
            chk($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eo, tbl[i].ea);
        end

        // Simultaneous down+right: down wins, right never follows while held.
        run(4'b1010, 1'b1, 1'b0, 6);
        chk("simul_edge6", 1'b0, 2'd0, 4'b0000, 1'b1);
        run(4'b1010, 1'b1, 1'b0, 1);
        chk("simul_edge7", 1'b1, 2'd1, 4'b0010, 1'b1);
        run(4'b1010, 1'b1, 1'b1, 1);
        chk("simul_consume", 1'b0, 2'd1, 4'b0000, 1'b1);
        run(4'b1010, 1'b1, 1'b0, 8);
        chk("simul_no_right", 1'b0, 2'd1, 4'b0000, 1'b1);
        run(4'b0000, 1'b1, 1'b0, 8);
        chk("simul_release", 1'b0, 2'd1, 4'b0000, 1'b0);

        // Slot full: left queued, right dropped; then consume with a same-edge up press.
        run(4'b0100, 1'b1, 1'b0, 7);
        chk("full_left", 1'b1, 2'd2, 4'b0100, 1'b1);
        run(4'b1100, 1'b1, 1'b0, 8);
        chk("full_right_dropped", 1'b1, 2'd2, 4'b0100, 1'b1);
        run(4'b1101, 1'b1, 1'b0, 6);
        chk("full_before_reload", 1'b1, 2'd2, 4'b0100, 1'b1);
        run(4'b1101, 1'b1, 1'b1, 1);
        chk("consume_reload_up", 1'b1, 2'd0, 4'b0001, 1'b1);
        run(4'b0000, 1'b1, 1'b0, 8);
        chk("hold_without_tick", 1'b1, 2'd0, 4'b0001, 1'b0);
        run(4'b0000, 1'b1, 1'b1, 1);
        chk("consume_up", 1'b0, 2'd0, 4'b0000, 1'b0);

        // Enable low: presses discarded, pending move flushed.
        run(4'b0010, 1'b0, 1'b0, 8);
        chk("disabled_press", 1'b0, 2'd0, 4'b0000, 1'b1);
        run(4'b0010, 1'b1, 1'b0, 3);
        chk("enable_while_held", 1'b0, 2'd0, 4'b0000, 1'b1);
        run(4'b0000, 1'b1, 1'b0, 8);
        chk("disabled_release", 1'b0, 2'd0, 4'b0000, 1'b0);
        run(4'b1000, 1'b1, 1'b0, 7);
        chk("pending_right", 1'b1, 2'd3, 4'b1000, 1'b1);
        run(4'b1000, 1'b0, 1'b0, 1);
        chk("enable_flush", 1'b0, 2'd3, 4'b0000, 1'b1);
        run(4'b0000, 1'b0, 1'b0, 8);
        chk("flush_release", 1'b0, 2'd3, 4'b0000, 1'b0);

        // Async reset mid-operation, then right held through reset release.
        run(4'b0010, 1'b1, 1'b0, 7);
        chk("pre_reset_down", 1'b1, 2'd1, 4'b0010, 1'b1);
        btn_raw = 4'b1000;
        #3 reset = 1'b1;
        #1 chk("async_reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        run(4'b1000, 1'b1, 1'b0, 6);
        chk("post_reset_edge6", 1'b0, 2'd0, 4'b0000, 1'b1);
        run(4'b1000, 1'b1, 1'b0, 1);
        chk("post_reset_edge7", 1'b1, 2'd3, 4'b1000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/move_input_conditioner.md
# move_input_conditioner

Conditions the four raw game buttons for the 2048 VGA top level and turns each clean press into exactly one queued move command. It sits between the asynchronous `ui_in[3:0]` pins and the game-logic stage. Moves are held in a one-entry slot until the game consumes them on the frame tick (vsync rising-edge pulse). It also exports a debounced "any button held" level for leaving the welcome screen.

## Interface

Parameters:
- `DEBOUNCE_BITS`, 18, debounce counter width. A level change must persist for 2^DEBOUNCE_BITS consecutive cycles, about 10.4 ms at 25.175 MHz.

Ports:
- `clk`  in  1  pixel clock, the single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_raw`  in  4  raw buttons, asynchronous: bit0 up, bit1 down, bit2 left, bit3 right.
- `frame_tick`  in  1  one-cycle consume strobe (vsync rising edge).
- `enable`  in  1  0 = discard presses and flush the slot (welcome screen active).
- `move_valid`  out  1  a move is pending.
- `move_dir`  out  2  encoding of the pending move: 0 up, 1 down, 2 left, 3 right.
- `move_onehot`  out  4  `{right,left,down,up}`, equal to the one-hot of `move_dir` when `move_valid`, else 0.
- `any_pressed`  out  1  OR of the debounced button levels.

## Operation

- **Synchronizer:** two flops per bit; stage-2 output is `sync[i]`.
- **Debouncer, per bit, independent:**
  - Holds `stable[i]` and a counter `cnt[i]`.
  - If `sync[i]==stable[i]`, `cnt` goes to 0.
  - Else, if `cnt==MAX` (all ones), `stable[i]` toggles and `cnt` goes to 0.
  - Else `cnt` increments.
  - Any glitch shorter than 2^DEBOUNCE_BITS cycles leaves `stable` unchanged.
- **Press event:** `press[i] = stable[i] & ~stable_d[i]`, where `stable_d` is `stable` delayed one cycle. Releases generate no event.
- **Slot update, evaluated in this order each cycle:**
  1. If `enable==0`: `move_valid` goes to 0 and all presses are discarded.
  2. Else, if `move_valid && frame_tick`: the move is consumed and the slot frees this cycle.
  3. If the slot is free (after step 2) and any `press` is set: load the highest-priority press (up > down > left > right) and set `move_valid` to 1. Other simultaneous presses are dropped.
  4. Presses arriving while the slot is occupied and not being consumed are dropped; the first move wins.
- **Field rules:**
  - `move_dir` holds its last value when `move_valid==0`.
  - `move_onehot` is combinational from `move_valid` and `move_dir`.
- **Held buttons:** a button held through reset release is seen as a press after debounce, because `stable` resets to 0. This is the intended behaviour.

## Timing

- **Reset values:** all synchronizer flops, `stable`, `stable_d` and `cnt` are 0. `move_valid=0`, `move_dir=0`, `move_onehot=0`, `any_pressed=0`.
- **Press latency:** let the first edge that samples `btn_raw[i]` high be edge 1.
  - `stable[i]` rises after edge 2^DEBOUNCE_BITS+2.
  - `any_pressed` rises after the same edge, since it is the OR of the `stable` registers.
  - `move_valid` rises after edge 2^DEBOUNCE_BITS+3, provided `enable` is 1 and the slot is free.
- **Release latency:** same as press latency; no move is produced.
- **Consume:** `move_valid` falls on the edge where `frame_tick` is sampled high, unless a press reloads the slot on that same edge. In that case `move_valid` stays 1 and `move_dir` takes the new value.
- **Enable:** `enable` falling clears `move_valid` on the next edge.
- **Reset mid-debounce:** asynchronous assertion zeroes everything immediately. A pending move is lost.

## Structure

- Package `game_input_pkg`:
  - Direction constants `DIR_UP=2'd0`, `DIR_DOWN=2'd1`, `DIR_LEFT=2'd2`, `DIR_RIGHT=2'd3`.
  - Default `DEBOUNCE_BITS`.
- Sub-module `button_debouncer` (one bit: synchronizer, counter and `stable`), instantiated four times.
- Priority select, slot register and one-hot decode live in the top of this block.

## Test plan

All scenarios use `DEBOUNCE_BITS=2`.

- **Clean press:** `btn_raw=4'b0001` from edge 1, `enable=1` -> `move_valid=1`, `move_dir=0`, `move_onehot=4'b0001` after edge 7; `any_pressed=1` after edge 6.
- **Glitch rejection:** `btn_raw[2]` pulses high for 3 cycles -> `stable`, `any_pressed` and `move_valid` stay 0 throughout.
- **Simultaneous press:** `btn_raw=4'b1010` stepped in one cycle -> `move_dir=1` (down). A `frame_tick` then clears `move_valid`, and no right move follows while both buttons stay held.
- **Slot full, then consume:** left queued, right pressed before any `frame_tick` -> left retained and right dropped. Next, `frame_tick` in the same cycle as a fresh up press -> `move_valid` stays 1 and `move_dir=0`.
- **Enable low:** press with `enable=0` -> `move_valid` stays 0 while `any_pressed=1`. A pending move plus `enable` going 0 -> `move_valid=0` next edge.
- **Async reset mid-operation:** assert `reset` between clock edges while `move_valid=1` -> all outputs 0 immediately. Holding `btn_raw[3]` through reset release -> `move_dir=3` after edge 7 of the post-reset count.
